// File: rtl/fp_regfile_sb_pkg.sv
// Shared definitions for the register file slice: write-back port indices and address width helper.
// No logic, no latency, no backpressure.
package regfile_pkg;

  localparam int NUM_WB  = 2;
  localparam int WB_FPU  = 0;
  localparam int WB_LOAD = 1;

  function automatic int calc_aw(input int num_regs);
    return (num_regs > 1) ? $clog2(num_regs) : 1;
  endfunction

endpackage

// File: rtl/fp_regfile_sb_if.sv
// Decode/write-back bus of the FP register file: read ports, allocation handshake, write-backs, status.
// Purely a signal bundle; slave modport is the register file side.
interface fp_regfile_sb_if
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 3,
  parameter int AW       = calc_aw(NUM_REGS)
);

  logic [NUM_RD*AW-1:0]     rd_addr_i;
  logic [NUM_RD*DATA_W-1:0] rd_data_o;
  logic [NUM_RD-1:0]        rd_busy_o;
  logic                     alloc_valid_i;
  logic [AW-1:0]            alloc_rd_i;
  logic                     alloc_ready_o;
  logic [NUM_WB-1:0]        wb_valid_i;
  logic [NUM_WB*AW-1:0]     wb_addr_i;
  logic [NUM_WB*DATA_W-1:0] wb_data_i;
  logic                     flush_i;
  logic [AW:0]              pending_o;
  logic                     wb_unexp_o;

  modport slave (
    input  rd_addr_i, alloc_valid_i, alloc_rd_i, wb_valid_i, wb_addr_i, wb_data_i, flush_i,
    output rd_data_o, rd_busy_o, alloc_ready_o, pending_o, wb_unexp_o
  );

  modport master (
    output rd_addr_i, alloc_valid_i, alloc_rd_i, wb_valid_i, wb_addr_i, wb_data_i, flush_i,
    input  rd_data_o, rd_busy_o, alloc_ready_o, pending_o, wb_unexp_o
  );

endinterface

// File: rtl/fp_regfile_sb_scoreboard.sv
// Busy-bit scoreboard: allocation handshake, write-back clears, flush, pending count, unexpected-wb flag.
// Busy lookups and alloc_ready_o are combinational; state updates at the edge; allocation stalls while busy.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 3,
  parameter bit ZERO_REG = 1'b0,
  parameter int AW       = calc_aw(NUM_REGS)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NUM_RD*AW-1:0] rd_addr_i,
  output logic [NUM_RD-1:0]    rd_busy_o,
  input  logic                 alloc_valid_i,
  input  logic [AW-1:0]        alloc_rd_i,
  output logic                 alloc_ready_o,
  input  logic [NUM_WB-1:0]    wb_valid_i,
  input  logic [NUM_WB*AW-1:0] wb_addr_i,
  input  logic                 flush_i,
  output logic [AW:0]          pending_o,
  output logic                 wb_unexp_o
);

  localparam int PW = AW + 1;

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [NUM_REGS-1:0] clr_vec, set_vec;
  logic [PW-1:0]       pending_q, pending_d;
  logic                wb_unexp_q, wb_unexp_d;
  logic                alloc_zero;

  always_comb begin
    clr_vec    = '0;
    wb_unexp_d = 1'b0;
    for (int p = 0; p < NUM_WB; p++) begin
      if (wb_valid_i[p]) begin
        clr_vec[wb_addr_i[p*AW +: AW]] = 1'b1;
        if (!busy_q[wb_addr_i[p*AW +: AW]]) wb_unexp_d = 1'b1;
      end
    end
  end

  assign alloc_zero    = ZERO_REG && (alloc_rd_i == '0);
  assign alloc_ready_o = !busy_q[alloc_rd_i] || clr_vec[alloc_rd_i] || alloc_zero;

  // A same-cycle set and clear on one register leaves it busy; the counter
  // sees +1 and -1, which nets out because the bit was already counted.
  always_comb begin
    set_vec = '0;
    if (alloc_valid_i && alloc_ready_o && !alloc_zero && !flush_i) set_vec[alloc_rd_i] = 1'b1;
    busy_d    = flush_i ? '0 : ((busy_q & ~clr_vec) | set_vec);
    pending_d = pending_q + PW'(set_vec != '0) - PW'($countones(busy_q & clr_vec));
    if (flush_i) pending_d = '0;
  end

  always_comb begin
    rd_busy_o = '0;
    for (int k = 0; k < NUM_RD; k++) rd_busy_o[k] = busy_q[rd_addr_i[k*AW +: AW]];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q     <= '0;
      pending_q  <= '0;
      wb_unexp_q <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      pending_q  <= pending_d;
      wb_unexp_q <= wb_unexp_d;
    end
  end

  assign pending_o  = pending_q;
  assign wb_unexp_o = wb_unexp_q;

endmodule

// File: rtl/fp_regfile_sb.sv
// FP register file with scoreboard: NUM_RD combinational reads, two write-backs (FPU beats load).
// Reads 0-cycle, writes land at the edge; optional same-cycle bypass under FPRF_BYPASS_EN; decode stalls via alloc_ready_o.
module fp_regfile_sb
  import regfile_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                NUM_REGS = 32,
  parameter int                NUM_RD   = 3,
  parameter bit                ZERO_REG = 1'b0,
  parameter int                INIT_IDX = 2,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input logic           clk_i,
  input logic           rst_ni,
  fp_regfile_sb_if.slave bus
);

  localparam int AW = calc_aw(NUM_REGS);

  logic [DATA_W-1:0]        regs_q [NUM_REGS];
  logic [DATA_W-1:0]        regs_d [NUM_REGS];
  logic [NUM_RD-1:0]        sb_busy;
  logic [NUM_RD-1:0]        rd_busy;
  logic [NUM_RD*DATA_W-1:0] rd_data;

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .NUM_RD   (NUM_RD),
    .ZERO_REG (ZERO_REG),
    .AW       (AW)
  ) u_sb (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .rd_addr_i     (bus.rd_addr_i),
    .rd_busy_o     (sb_busy),
    .alloc_valid_i (bus.alloc_valid_i),
    .alloc_rd_i    (bus.alloc_rd_i),
    .alloc_ready_o (bus.alloc_ready_o),
    .wb_valid_i    (bus.wb_valid_i),
    .wb_addr_i     (bus.wb_addr_i),
    .flush_i       (bus.flush_i),
    .pending_o     (bus.pending_o),
    .wb_unexp_o    (bus.wb_unexp_o)
  );

  // Load port is applied first so the FPU port overwrites it on an address clash.
  always_comb begin
    regs_d = regs_q;
    for (int p = NUM_WB - 1; p >= 0; p--) begin
      if (bus.wb_valid_i[p] && !(ZERO_REG && (bus.wb_addr_i[p*AW +: AW] == '0)))
        regs_d[bus.wb_addr_i[p*AW +: AW]] = bus.wb_data_i[p*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= (i == INIT_IDX) ? INIT_VAL : '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      rd_data[k*DATA_W +: DATA_W] = regs_q[bus.rd_addr_i[k*AW +: AW]];
      rd_busy[k]                  = sb_busy[k];
`ifdef FPRF_BYPASS_EN
      for (int p = NUM_WB - 1; p >= 0; p--) begin
        if (bus.wb_valid_i[p] && (bus.wb_addr_i[p*AW +: AW] == bus.rd_addr_i[k*AW +: AW])) begin
          rd_data[k*DATA_W +: DATA_W] = bus.wb_data_i[p*DATA_W +: DATA_W];
          rd_busy[k]                  = 1'b0;
        end
      end
`endif
      if (ZERO_REG && (bus.rd_addr_i[k*AW +: AW] == '0)) rd_data[k*DATA_W +: DATA_W] = '0;
    end
  end

  assign bus.rd_data_o = rd_data;
  assign bus.rd_busy_o = rd_busy;

endmodule
